// File: rtl/branch_redirect_ctrl.sv
// branch_redirect_ctrl: flushes IF/ID on a taken ID transfer, hands a registered redirect PC to fetch and drops wrong-path read beats
module branch_redirect_ctrl #(
  parameter int MAX_OUT = 2,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid,
  input  logic             id_stall,
  input  logic             id_taken,
  input  logic             id_jalr,
  input  logic [31:0]      id_target,
  input  logic             if_ar_fire,
  input  logic             if_r_fire,
  output logic             redir_valid,
  output logic [31:0]      redir_pc,
  input  logic             redir_ready,
  output logic             flush_ifid,
  output logic             drop_fetch,
  output logic             stall_id,
  output logic [CNT_W-1:0] redirect_cnt,
  output logic             proto_err
);
  localparam int CW = $clog2(MAX_OUT + 1);
  localparam logic [CW-1:0] MAX_C = CW'(MAX_OUT);
  typedef enum logic [1:0] {IDLE, REDIRECT, DRAIN} state_t;
  state_t state, nxt;
  logic [CW-1:0] out_cnt, out_cnt_next, drop_cnt;
  logic accept, ovf, unf;
  assign accept = state == IDLE && id_valid && !id_stall && (id_taken || id_jalr);
  assign ovf = if_ar_fire && !if_r_fire && out_cnt == MAX_C;
  assign unf = if_r_fire && !if_ar_fire && out_cnt == '0;
  assign out_cnt_next = (ovf || unf) ? out_cnt : out_cnt + CW'(if_ar_fire) - CW'(if_r_fire);
  always_ff @(posedge clk)
    if (rst) state <= IDLE;
    else state <= nxt;
  always_comb
    nxt = state == IDLE     ? (accept ? REDIRECT : IDLE) :
          state == REDIRECT ? (redir_ready ? (out_cnt_next != '0 ? DRAIN : IDLE) : REDIRECT) :
                              (if_r_fire && drop_cnt == CW'(1) ? IDLE : DRAIN);
  always_comb begin
    flush_ifid = accept || state == REDIRECT;
    stall_id = state != IDLE;
    drop_fetch = state != IDLE && if_r_fire;
  end
  always_ff @(posedge clk)
    if (rst) begin
      redir_valid <= 1'b0;
      redir_pc <= '0;
      redirect_cnt <= '0;
      proto_err <= 1'b0;
      out_cnt <= '0;
      drop_cnt <= '0;
    end else begin
      redir_valid <= nxt == REDIRECT;
      if (accept) redir_pc <= {id_target[31:1], id_target[0] & ~id_jalr};
      if (state == REDIRECT && redir_ready) begin
        redirect_cnt <= redirect_cnt + CNT_W'(1);
        drop_cnt <= out_cnt_next;
      end else if (state == DRAIN && if_r_fire) drop_cnt <= drop_cnt - CW'(1);
      out_cnt <= out_cnt_next;
      if (ovf || unf) proto_err <= 1'b1;
    end
endmodule

// File: tb/tb_branch_redirect_ctrl.sv
// tb_branch_redirect_ctrl: directed cycle-by-cycle vectors for branch_redirect_ctrl
module tb_branch_redirect_ctrl;
  logic clk = 0, rst = 1;
  logic id_valid = 0, id_stall = 0, id_taken = 0, id_jalr = 0;
  logic [31:0] id_target = 0;
  logic if_ar_fire = 0, if_r_fire = 0, redir_ready = 0;
  logic redir_valid, flush_ifid, drop_fetch, stall_id, proto_err;
  logic [31:0] redir_pc;
  logic [15:0] redirect_cnt;
  int checks = 0, failures = 0;
  typedef struct {
    logic v, s, t, j;
    logic [31:0] tgt;
    logic ar, r, rdy;
    logic [52:0] exp;
  } vec_t;
  vec_t vecs[$];
  branch_redirect_ctrl #(.MAX_OUT(2), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_stall(id_stall), .id_taken(id_taken),
    .id_jalr(id_jalr), .id_target(id_target), .if_ar_fire(if_ar_fire), .if_r_fire(if_r_fire),
    .redir_valid(redir_valid), .redir_pc(redir_pc), .redir_ready(redir_ready),
    .flush_ifid(flush_ifid), .drop_fetch(drop_fetch), .stall_id(stall_id),
    .redirect_cnt(redirect_cnt), .proto_err(proto_err)
  );
  always #5 clk = ~clk;
  function automatic vec_t mk(logic v, logic s, logic t, logic j, logic [31:0] tgt,
                              logic ar, logic r, logic rdy, logic rv, logic [31:0] pc,
                              logic fl, logic dr, logic sv, logic [15:0] cnt, logic pe);
    vec_t x;
    x.v = v; x.s = s; x.t = t; x.j = j; x.tgt = tgt;
    x.ar = ar; x.r = r; x.rdy = rdy;
    x.exp = {rv, pc, fl, dr, sv, cnt, pe};
    return x;
  endfunction
  task automatic drive(vec_t x);
    id_valid = x.v; id_stall = x.s; id_taken = x.t; id_jalr = x.j; id_target = x.tgt;
    if_ar_fire = x.ar; if_r_fire = x.r; redir_ready = x.rdy;
  endtask
  initial begin
    logic [52:0] act;
    // v s t j tgt | ar r rdy | redir_valid redir_pc flush drop stall cnt proto_err
    vecs.push_back(mk(0,0,0,0,32'h0,    0,0,0, 0,32'h0,   0,0,0,0,0));
    vecs.push_back(mk(1,0,1,0,32'h100,  0,0,1, 0,32'h0,   1,0,0,0,0));
    vecs.push_back(mk(0,0,0,0,32'h0,    0,0,1, 1,32'h100, 1,0,1,0,0));
    vecs.push_back(mk(0,0,0,0,32'h0,    0,0,0, 0,32'h100, 0,0,0,1,0));
    vecs.push_back(mk(1,0,0,1,32'h2003, 0,0,0, 0,32'h100, 1,0,0,1,0));
    vecs.push_back(mk(0,0,0,0,32'h0,    0,0,0, 1,32'h2002,1,0,1,1,0));
    vecs.push_back(mk(1,0,1,0,32'h3000, 0,0,0, 1,32'h2002,1,0,1,1,0));
    vecs.push_back(mk(0,0,0,0,32'h0,    0,0,0, 1,32'h2002,1,0,1,1,0));
    vecs.push_back(mk(0,0,0,0,32'h0,    0,0,1, 1,32'h2002,1,0,1,1,0));
    vecs.push_back(mk(0,0,0,0,32'h0,    0,0,0, 0,32'h2002,0,0,0,2,0));
    vecs.push_back(mk(0,0,0,0,32'h0,    1,0,0, 0,32'h2002,0,0,0,2,0));
    vecs.push_back(mk(0,0,0,0,32'h0,    1,0,0, 0,32'h2002,0,0,0,2,0));
    vecs.push_back(mk(1,0,1,0,32'h400,  0,0,1, 0,32'h2002,1,0,0,2,0));
    vecs.push_back(mk(0,0,0,0,32'h0,    0,0,1, 1,32'h400, 1,0,1,2,0));
    vecs.push_back(mk(0,0,0,0,32'h0,    0,1,0, 0,32'h400, 0,1,1,3,0));
    vecs.push_back(mk(0,0,0,0,32'h0,    1,0,0, 0,32'h400, 0,0,1,3,0));
    vecs.push_back(mk(0,0,0,0,32'h0,    0,0,0, 0,32'h400, 0,0,1,3,0));
    vecs.push_back(mk(0,0,0,0,32'h0,    0,1,0, 0,32'h400, 0,1,1,3,0));
    vecs.push_back(mk(0,0,0,0,32'h0,    0,1,0, 0,32'h400, 0,0,0,3,0));
    vecs.push_back(mk(0,0,0,0,32'h0,    1,0,0, 0,32'h400, 0,0,0,3,0));
    vecs.push_back(mk(1,0,1,0,32'h800,  0,0,0, 0,32'h400, 1,0,0,3,0));
    vecs.push_back(mk(0,0,0,0,32'h0,    1,0,1, 1,32'h800, 1,0,1,3,0));
    vecs.push_back(mk(0,0,0,0,32'h0,    0,1,0, 0,32'h800, 0,1,1,4,0));
    vecs.push_back(mk(0,0,0,0,32'h0,    0,1,0, 0,32'h800, 0,1,1,4,0));
    vecs.push_back(mk(0,0,0,0,32'h0,    1,0,0, 0,32'h800, 0,0,0,4,0));
    vecs.push_back(mk(0,0,0,0,32'h0,    0,1,0, 0,32'h800, 0,0,0,4,0));
    vecs.push_back(mk(1,1,1,0,32'h1000, 0,0,1, 0,32'h800, 0,0,0,4,0));
    vecs.push_back(mk(1,1,1,0,32'h1000, 0,0,1, 0,32'h800, 0,0,0,4,0));
    vecs.push_back(mk(1,0,1,0,32'h1000, 0,0,1, 0,32'h800, 1,0,0,4,0));
    vecs.push_back(mk(0,0,0,0,32'h0,    0,0,1, 1,32'h1000,1,0,1,4,0));
    vecs.push_back(mk(0,0,0,0,32'h0,    0,0,0, 0,32'h1000,0,0,0,5,0));
    vecs.push_back(mk(0,0,1,0,32'h5000, 0,0,0, 0,32'h1000,0,0,0,5,0));
    vecs.push_back(mk(1,0,0,0,32'h5000, 0,0,0, 0,32'h1000,0,0,0,5,0));
    vecs.push_back(mk(0,0,0,0,32'h0,    1,0,0, 0,32'h1000,0,0,0,5,0));
    vecs.push_back(mk(0,0,0,0,32'h0,    1,0,0, 0,32'h1000,0,0,0,5,0));
    vecs.push_back(mk(0,0,0,0,32'h0,    1,0,0, 0,32'h1000,0,0,0,5,0));
    vecs.push_back(mk(1,0,1,0,32'h2000, 0,0,0, 0,32'h1000,1,0,0,5,1));
    vecs.push_back(mk(0,0,0,0,32'h0,    0,0,1, 1,32'h2000,1,0,1,5,1));
    vecs.push_back(mk(0,0,0,0,32'h0,    0,1,0, 0,32'h2000,0,1,1,6,1));
    vecs.push_back(mk(0,0,0,0,32'h0,    0,1,0, 0,32'h2000,0,1,1,6,1));
    vecs.push_back(mk(0,0,0,0,32'h0,    0,0,0, 0,32'h2000,0,0,0,6,1));
    vecs.push_back(mk(1,0,1,0,32'h3000, 0,0,0, 0,32'h2000,1,0,0,6,1));
    vecs.push_back(mk(0,0,0,0,32'h0,    0,0,0, 0,32'h0,   0,0,0,0,0));
    vecs.push_back(mk(0,0,0,0,32'h0,    0,1,0, 0,32'h0,   0,0,0,0,0));
    vecs.push_back(mk(0,0,0,0,32'h0,    0,0,0, 0,32'h0,   0,0,0,0,1));
    vecs.push_back(mk(0,0,0,0,32'h0,    1,0,0, 0,32'h0,   0,0,0,0,1));
    vecs.push_back(mk(1,0,1,0,32'h44,   0,0,0, 0,32'h0,   1,0,0,0,1));
    vecs.push_back(mk(0,0,0,0,32'h0,    0,0,1, 1,32'h44,  1,0,1,0,1));
    vecs.push_back(mk(0,0,0,0,32'h0,    0,1,0, 0,32'h44,  0,1,1,1,1));
    vecs.push_back(mk(0,0,0,0,32'h0,    0,0,0, 0,32'h44,  0,0,0,1,1));
    @(negedge clk);
    @(negedge clk);
    rst = 0;
    foreach (vecs[i]) begin
      if (i == 42) begin
        // reset while a redirect is pending, with an AR and ready firing in the same cycle
        @(negedge clk);
        drive(mk(0,0,0,0,32'h0, 1,0,1, 0,32'h0,0,0,0,0,0));
        rst = 1;
        #1;
        checks++;
        if (!(redir_valid === 1'b1 && redir_pc === 32'h3000)) begin
          failures++;
          $display("FAIL pending_before_rst: got valid=%b pc=%h, want valid=1 pc=00003000", redir_valid, redir_pc);
        end
        @(negedge clk);
        rst = 0;
        drive(mk(0,0,0,0,32'h0, 0,0,0, 0,32'h0,0,0,0,0,0));
      end
      @(negedge clk);
      drive(vecs[i]);
      #1;
      act = {redir_valid, redir_pc, flush_ifid, drop_fetch, stall_id, redirect_cnt, proto_err};
      checks++;
      if (act !== vecs[i].exp) begin
        failures++;
        $display("FAIL vec%0d: got rv=%b pc=%h fl=%b dr=%b st=%b cnt=%0d pe=%b, want rv=%b pc=%h fl=%b dr=%b st=%b cnt=%0d pe=%b",
                 i, act[52], act[51:20], act[19], act[18], act[17], act[16:1], act[0],
                 vecs[i].exp[52], vecs[i].exp[51:20], vecs[i].exp[19], vecs[i].exp[18],
                 vecs[i].exp[17], vecs[i].exp[16:1], vecs[i].exp[0]);
      end
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
